// File: rtl/sram_nr1w.sv
// N-read/1-write synchronous SRAM: registered reads, optional same-cycle write forwarding.
// Define SRAM_CLEAR_ON_RESET_EN to build in the post-reset clear engine that zeroes the array.
module sram_nr1w #(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 128,
    parameter int    READ_PORTS        = 2,
    parameter string READ_DURING_WRITE = "NEW_DATA",
    parameter int    ADDR_WIDTH        = $clog2(SIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS-1:0]            read_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
    input  logic                             write_en,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            write_data,
    output logic                             init_busy
);

    localparam bit FORWARD = (READ_DURING_WRITE == "NEW_DATA");

    // SIZE need not be a power of two, so the top of the address space can be unbacked.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return 32'(addr) < 32'(SIZE);
    endfunction

    // NOTE: the array itself has no reset; only the clear engine (when built in) defines its contents.
    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic                  clearing;
    logic                  write_ok;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef SRAM_CLEAR_ON_RESET_EN
    localparam logic [0:0]            ST_CLEAR  = 1'b0;
    localparam logic [0:0]            ST_READY  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clear_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CLEAR;
            clear_count <= '0;
        end else if (state == ST_CLEAR) begin
            if (clear_count == LAST_ADDR) begin
                state <= ST_READY;
            end
            clear_count <= clear_count + 1'b1;
        end
    end

    assign clearing = (state == ST_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    // External writes are dropped (never queued) while clearing or when out of range.
    assign write_ok  = write_en && !reset && !clearing && in_range(write_addr);
    assign init_busy = clearing;

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        mem_we    = write_ok;
        mem_waddr = write_addr;
        mem_wdata = write_data;
`ifdef SRAM_CLEAR_ON_RESET_EN
        if (clearing && !reset) begin
            mem_we    = 1'b1;
            mem_waddr = clear_count;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  fwd;
        logic                  hit;

        assign addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign fwd  = FORWARD && write_ok && (addr == write_addr);
        assign hit  = !clearing && in_range(addr);

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
            end else if (read_en[p]) begin
                if (fwd) begin
                    data_q <= write_data;
                end else if (hit) begin
                    data_q <= mem[addr];
                end else begin
                    data_q <= '0;
                end
            end
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
    end

endmodule

// File: tb/tb_sram_nr1w.sv
// Bench for sram_nr1w: directed scenarios plus random traffic against an array model.
// Expectations follow SRAM_CLEAR_ON_RESET_EN so the same bench covers both builds.
module tb_sram_nr1w;

`ifdef SRAM_CLEAR_ON_RESET_EN
    localparam logic EXP_BUSY_RST = 1'b1;
    localparam int   EXP_CLEAR_A  = 128;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
    localparam int   EXP_CLEAR_A  = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut_a (NEW_DATA) and dut_b (DONT_CARE) share one set of inputs.
    logic [1:0]  a_read_en;
    logic [13:0] a_read_addr;
    logic [63:0] a_read_data, b_read_data;
    logic        a_write_en;
    logic [6:0]  a_write_addr;
    logic [31:0] a_write_data;
    logic        a_busy, b_busy;

    logic [1:0]  c_read_en;
    logic [11:0] c_read_addr;
    logic [63:0] c_read_data;
    logic        c_write_en;
    logic [5:0]  c_write_addr;
    logic [31:0] c_write_data;
    logic        c_busy;

    logic [3:0]  d_read_en;
    logic [15:0] d_read_addr;
    logic [27:0] d_read_data;
    logic        d_write_en;
    logic [3:0]  d_write_addr;
    logic [6:0]  d_write_data;
    logic        d_busy;

    int total  = 0;
    int passed = 0;

    logic [31:0] model_a [128];
    bit          known_a [128];

    sram_nr1w #(.DATA_WIDTH(32), .SIZE(128), .READ_PORTS(2), .READ_DURING_WRITE("NEW_DATA")) dut_a (
        .clk(clk), .reset(reset), .read_en(a_read_en), .read_addr(a_read_addr), .read_data(a_read_data),
        .write_en(a_write_en), .write_addr(a_write_addr), .write_data(a_write_data), .init_busy(a_busy));

    sram_nr1w #(.DATA_WIDTH(32), .SIZE(128), .READ_PORTS(2), .READ_DURING_WRITE("DONT_CARE")) dut_b (
        .clk(clk), .reset(reset), .read_en(a_read_en), .read_addr(a_read_addr), .read_data(b_read_data),
        .write_en(a_write_en), .write_addr(a_write_addr), .write_data(a_write_data), .init_busy(b_busy));

    sram_nr1w #(.DATA_WIDTH(32), .SIZE(52), .READ_PORTS(2), .READ_DURING_WRITE("NEW_DATA")) dut_c (
        .clk(clk), .reset(reset), .read_en(c_read_en), .read_addr(c_read_addr), .read_data(c_read_data),
        .write_en(c_write_en), .write_addr(c_write_addr), .write_data(c_write_data), .init_busy(c_busy));

    sram_nr1w #(.DATA_WIDTH(7), .SIZE(16), .READ_PORTS(4), .READ_DURING_WRITE("NEW_DATA")) dut_d (
        .clk(clk), .reset(reset), .read_en(d_read_en), .read_addr(d_read_addr), .read_data(d_read_data),
        .write_en(d_write_en), .write_addr(d_write_addr), .write_data(d_write_data), .init_busy(d_busy));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_read_en = '0; a_write_en = 1'b0;
        c_read_en = '0; c_write_en = 1'b0;
        d_read_en = '0; d_write_en = 1'b0;
    endtask

    task automatic a_write(input logic [6:0] addr, input logic [31:0] data);
        a_write_en = 1'b1; a_write_addr = addr; a_write_data = data;
        model_a[addr] = data; known_a[addr] = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        a_read_addr = '0; c_read_addr = '0; d_read_addr = '0;
        a_write_addr = '0; a_write_data = '0; c_write_addr = '0; c_write_data = '0;
        d_write_addr = '0; d_write_data = '0;
        reset = 1'b1;
        step();
        step();
        for (int i = 0; i < 128; i++) known_a[i] = 1'b0;
        total++; if (a_read_data !== 64'd0) $display("FAIL reset_a_data: got %h expected 0", a_read_data); else passed++;
        total++; if (b_read_data !== 64'd0) $display("FAIL reset_b_data: got %h expected 0", b_read_data); else passed++;
        total++; if (c_read_data !== 64'd0) $display("FAIL reset_c_data: got %h expected 0", c_read_data); else passed++;
        total++; if (d_read_data !== 28'd0) $display("FAIL reset_d_data: got %h expected 0", d_read_data); else passed++;
        total++; if (a_busy !== EXP_BUSY_RST) $display("FAIL reset_busy_a: got %b expected %b", a_busy, EXP_BUSY_RST); else passed++;
        total++; if (b_busy !== EXP_BUSY_RST) $display("FAIL reset_busy_b: got %b expected %b", b_busy, EXP_BUSY_RST); else passed++;
        total++; if (c_busy !== EXP_BUSY_RST) $display("FAIL reset_busy_c: got %b expected %b", c_busy, EXP_BUSY_RST); else passed++;
        total++; if (d_busy !== EXP_BUSY_RST) $display("FAIL reset_busy_d: got %b expected %b", d_busy, EXP_BUSY_RST); else passed++;
    endtask

    task automatic test_clear();
        int cnt = 0;
        reset = 1'b0;
        // Writes offered during the clear must be dropped and must not forward.
        while (a_busy === 1'b1 && cnt < 1000) begin
            a_write_en = 1'b1; a_write_addr = 7'd2; a_write_data = 32'hBAD0BAD0;
            a_read_en = 2'b11;
            a_read_addr = {7'($urandom_range(0, 127)), 7'd2};
            step();
            cnt++;
            total++; if (a_read_data !== 64'd0) $display("FAIL clear_read: got %h expected 0", a_read_data); else passed++;
        end
        idle();
        total++; if (cnt !== EXP_CLEAR_A) $display("FAIL clear_cycles: got %0d expected %0d", cnt, EXP_CLEAR_A); else passed++;
        total++; if (c_busy !== 1'b0) $display("FAIL clear_done_c: got %b expected 0", c_busy); else passed++;
        total++; if (d_busy !== 1'b0) $display("FAIL clear_done_d: got %b expected 0", d_busy); else passed++;
`ifdef SRAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 128; i++) begin
            model_a[i] = 32'd0; known_a[i] = 1'b1;
        end
`endif
        // Sweep every address on both ports; the first sweep cycle also carries the first write.
        for (int i = 0; i < 128; i++) begin
            logic [6:0]  addr [2];
            logic [31:0] exp  [2];
            bit          val  [2];
            addr[0] = 7'(i); addr[1] = 7'(127 - i);
            for (int p = 0; p < 2; p++) begin
                exp[p] = model_a[addr[p]]; val[p] = known_a[addr[p]];
            end
            a_read_en = 2'b11;
            a_read_addr = {addr[1], addr[0]};
            a_write_en = 1'b0;
            if (i == 0) a_write(7'd1, 32'h5A5A5A5A);
            step();
            for (int p = 0; p < 2; p++) begin
                if (val[p]) begin
                    total++;
                    if (a_read_data[p*32 +: 32] !== exp[p]) $display("FAIL sweep_a p%0d @%0d: got %h expected %h", p, addr[p], a_read_data[p*32 +: 32], exp[p]); else passed++;
                    total++;
                    if (b_read_data[p*32 +: 32] !== exp[p]) $display("FAIL sweep_b p%0d @%0d: got %h expected %h", p, addr[p], b_read_data[p*32 +: 32], exp[p]); else passed++;
                end
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        a_write(7'd9, 32'h00000055);
        step();
        idle();
        a_read_en = 2'b10; a_read_addr = {7'd9, 7'd0};
        step();
        total++; if (a_read_data[63:32] !== 32'h55) $display("FAIL wr_prime_p1: got %h expected 00000055", a_read_data[63:32]); else passed++;
        idle();
        a_write(7'd5, 32'hDEADBEEF);
        step();
        idle();
        a_read_en = 2'b01; a_read_addr = {7'd0, 7'd5};
        step();
        total++; if (a_read_data[31:0] !== 32'hDEADBEEF) $display("FAIL wr_read_p0: got %h expected deadbeef", a_read_data[31:0]); else passed++;
        total++; if (a_read_data[63:32] !== 32'h55) $display("FAIL wr_hold_p1: got %h expected 00000055", a_read_data[63:32]); else passed++;
        idle();
        a_read_addr = {7'd1, 7'd1};
        step();
        total++; if (a_read_data !== {32'h55, 32'hDEADBEEF}) $display("FAIL wr_hold_both: got %h expected %h", a_read_data, {32'h55, 32'hDEADBEEF}); else passed++;
    endtask

    task automatic test_forwarding();
        a_write(7'd7, 32'h0000AAAA);
        step();
        idle();
        a_write_en = 1'b1; a_write_addr = 7'd7; a_write_data = 32'h00001234;
        a_read_en = 2'b11; a_read_addr = {7'd7, 7'd7};
        step();
        model_a[7] = 32'h00001234;
        total++; if (a_read_data !== {2{32'h00001234}}) $display("FAIL fwd_new_data: got %h expected %h", a_read_data, {2{32'h00001234}}); else passed++;
        total++; if (b_read_data !== {2{32'h0000AAAA}}) $display("FAIL fwd_dont_care: got %h expected %h", b_read_data, {2{32'h0000AAAA}}); else passed++;
        a_write_en = 1'b0;
        step();
        total++; if (a_read_data !== {2{32'h00001234}}) $display("FAIL fwd_after_a: got %h expected %h", a_read_data, {2{32'h00001234}}); else passed++;
        total++; if (b_read_data !== {2{32'h00001234}}) $display("FAIL fwd_after_b: got %h expected %h", b_read_data, {2{32'h00001234}}); else passed++;
        idle();
    endtask

    task automatic test_out_of_range();
        c_write_en = 1'b1; c_write_addr = 6'd8;  c_write_data = 32'h77; step();
        c_write_addr = 6'd28; c_write_data = 32'h28; step();
        c_write_addr = 6'd51; c_write_data = 32'h51;
        c_read_en = 2'b11; c_read_addr = {6'd28, 6'd8};
        step();
        total++; if (c_read_data !== {32'h28, 32'h77}) $display("FAIL oor_prime: got %h expected %h", c_read_data, {32'h28, 32'h77}); else passed++;
        // Out-of-range write and read in the same cycle: dropped, no forwarding, read loads 0.
        c_write_addr = 6'd60; c_write_data = 32'hFF;
        c_read_addr = {6'd51, 6'd60};
        step();
        total++; if (c_read_data !== {32'h51, 32'h0}) $display("FAIL oor_same_cycle: got %h expected %h", c_read_data, {32'h51, 32'h0}); else passed++;
        c_write_addr = 6'd52; c_write_data = 32'hEE;
        c_read_addr = {6'd8, 6'd51};
        step();
        total++; if (c_read_data !== {32'h77, 32'h51}) $display("FAIL oor_last_entry: got %h expected %h", c_read_data, {32'h77, 32'h51}); else passed++;
        c_write_en = 1'b0;
        c_read_addr = {6'd52, 6'd60};
        step();
        total++; if (c_read_data !== 64'd0) $display("FAIL oor_read_zero: got %h expected 0", c_read_data); else passed++;
        c_read_addr = {6'd28, 6'd8};
        step();
        total++; if (c_read_data !== {32'h28, 32'h77}) $display("FAIL oor_no_alias: got %h expected %h", c_read_data, {32'h28, 32'h77}); else passed++;
        c_read_addr = {6'd51, 6'd63};
        step();
        total++; if (c_read_data !== {32'h51, 32'h0}) $display("FAIL oor_top: got %h expected %h", c_read_data, {32'h51, 32'h0}); else passed++;
        idle();
    endtask

    task automatic test_wide_ports();
        logic [3:0] addrs [4];
        addrs[0] = 4'd3; addrs[1] = 4'd6; addrs[2] = 4'd9; addrs[3] = 4'd12;
        for (int i = 0; i < 4; i++) begin
            d_write_en = 1'b1; d_write_addr = addrs[i]; d_write_data = 7'(i + 1);
            step();
        end
        d_write_en = 1'b0;
        d_read_en = 4'hF;
        d_read_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};
        step();
        for (int p = 0; p < 4; p++) begin
            total++;
            if (d_read_data[p*7 +: 7] !== 7'(p + 1)) $display("FAIL wide_port%0d: got %h expected %h", p, d_read_data[p*7 +: 7], 7'(p + 1)); else passed++;
        end
        d_read_addr = {addrs[0], addrs[1], addrs[2], addrs[3]};
        step();
        total++; if (d_read_data !== {7'd1, 7'd2, 7'd3, 7'd4}) $display("FAIL wide_packed: got %h expected %h", d_read_data, {7'd1, 7'd2, 7'd3, 7'd4}); else passed++;
        d_write_en = 1'b1; d_write_addr = 4'd15; d_write_data = 7'h7F;
        d_read_en = 4'h0;
        step();
        d_write_en = 1'b0;
        d_read_en = 4'b1000; d_read_addr = {4'd15, 12'd0};
        step();
        total++; if (d_read_data !== {7'h7F, 7'd2, 7'd3, 7'd4}) $display("FAIL wide_hold: got %h expected %h", d_read_data, {7'h7F, 7'd2, 7'd3, 7'd4}); else passed++;
        idle();
    endtask

    task automatic test_random();
        logic [31:0] ea [2];
        logic [31:0] eb [2];
        bit          va [2];
        bit          vb [2];
        for (int p = 0; p < 2; p++) begin
            va[p] = 1'b0; vb[p] = 1'b0; ea[p] = '0; eb[p] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [6:0]  wa;
            logic [31:0] wd;
            logic [1:0]  re;
            logic [6:0]  ra [2];
            we = 1'($urandom_range(0, 1));
            wa = 7'($urandom_range(0, 15));
            wd = $urandom;
            for (int p = 0; p < 2; p++) begin
                re[p] = ($urandom_range(0, 3) != 0);
                ra[p] = 7'($urandom_range(0, 15));
                if (re[p]) begin
                    eb[p] = model_a[ra[p]]; vb[p] = known_a[ra[p]];
                    if (we && ra[p] == wa) begin
                        ea[p] = wd; va[p] = 1'b1;
                    end else begin
                        ea[p] = eb[p]; va[p] = vb[p];
                    end
                end
            end
            a_write_en = we; a_write_addr = wa; a_write_data = wd;
            a_read_en = re; a_read_addr = {ra[1], ra[0]};
            step();
            if (we) begin
                model_a[wa] = wd; known_a[wa] = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (va[p]) begin
                    total++;
                    if (a_read_data[p*32 +: 32] !== ea[p]) $display("FAIL rand_a n%0d p%0d: got %h expected %h", n, p, a_read_data[p*32 +: 32], ea[p]); else passed++;
                end
                if (vb[p]) begin
                    total++;
                    if (b_read_data[p*32 +: 32] !== eb[p]) $display("FAIL rand_b n%0d p%0d: got %h expected %h", n, p, b_read_data[p*32 +: 32], eb[p]); else passed++;
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int cnt = 0;
        a_write(7'd20, 32'h13579BDF);
        step();
        idle();
        a_read_en = 2'b11; a_read_addr = {7'd20, 7'd20};
        step();
        total++; if (a_read_data !== {2{32'h13579BDF}}) $display("FAIL mid_prime: got %h expected %h", a_read_data, {2{32'h13579BDF}}); else passed++;
        idle();
        reset = 1'b1;
        step();
        for (int i = 0; i < 128; i++) known_a[i] = 1'b0;
        total++; if (a_read_data !== 64'd0) $display("FAIL mid_reset_data: got %h expected 0", a_read_data); else passed++;
        total++; if (a_busy !== EXP_BUSY_RST) $display("FAIL mid_reset_busy: got %b expected %b", a_busy, EXP_BUSY_RST); else passed++;
        reset = 1'b0;
        repeat (40) step();
`ifdef SRAM_CLEAR_ON_RESET_EN
        total++; if (a_busy !== 1'b1) $display("FAIL mid_at_40: got %b expected 1", a_busy); else passed++;
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        while (a_busy === 1'b1 && cnt < 1000) begin
            a_write_en = (cnt == 5); a_write_addr = 7'd3; a_write_data = 32'hCAFEF00D;
            step();
            cnt++;
        end
        idle();
        total++; if (cnt !== EXP_CLEAR_A) $display("FAIL mid_clear_cycles: got %0d expected %0d", cnt, EXP_CLEAR_A); else passed++;
`ifdef SRAM_CLEAR_ON_RESET_EN
        a_write(7'd4, 32'h44);
        step();
        idle();
        a_read_en = 2'b11; a_read_addr = {7'd4, 7'd4};
        step();
        total++; if (a_read_data !== {2{32'h44}}) $display("FAIL mid_after_write: got %h expected %h", a_read_data, {2{32'h44}}); else passed++;
        a_read_addr = {7'd20, 7'd3};
        step();
        total++; if (a_read_data !== 64'd0) $display("FAIL mid_dropped_write: got %h expected 0", a_read_data); else passed++;
        idle();
`endif
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_forwarding();
        test_out_of_range();
        test_wide_ports();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
